trivium_keystream_par: RTL and testbench
========================================

Name: trivium_keystream_par

Overview:
- Parametrised successor to the single-bit Trivium core: full Trivium keystream generator with byte-serial key/IV loading, an internal warm-up sequencer and an OUT_W-bit-per-cycle keystream port.
- Keystream output uses a valid/ready handshake.
- Sits behind the TinyTapeout top wrapper: load bytes arrive on ui_in/uio_in, keystream words leave on uo_out.
- Replaces the 80-bit parallel key/IV test ports with an 8-bit load bus.

Parameters:
- OUT_W, 8: keystream bits per step; legal values 1, 2, 4, 8, 16, 32, 64.
- WARMUP, 1152: initialisation rounds, no output. Must be a multiple of OUT_W; default is the 4×288 value from the Trivium spec.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  global enable; when 0 all state frozen, outputs hold
- load_start  input  1  pulse: abort any operation, clear byte counter, enter LOAD
- load_valid  input  1  load_data byte valid this cycle
- load_data  input  8  key bytes 0..9 then IV bytes 0..9
- load_ready  output  1  high in LOAD state
- busy  output  1  high in LOAD or WARMUP
- ks_valid  output  1  ks_data holds an unconsumed word
- ks_ready  input  1  consumer accepts ks_data
- ks_data  output  OUT_W  keystream word; bit 0 = earliest z
- ks_count  output  32  words delivered (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state IDLE, 288-bit state s=0, byte counter 0, round counter 0, load_ready=0, busy=0, ks_valid=0, ks_data=0, ks_count=0.
- States: IDLE, LOAD, WARMUP, RUN. Every transition and register update is qualified by ena=1.
- load_start in any state → LOAD next cycle: byte counter cleared, ks_valid cleared, s cleared. load_start takes priority over every other event in the same cycle.
- LOAD: each cycle with load_valid=1 captures one byte. Byte b, bit j maps to key/IV bit i=8(b mod 10)+j (LSB first).
  - Key: s[i+1]=K_i, i.e. s1..s80.
  - IV: s[i+94]=IV_i, i.e. s94..s173.
  - After byte 19, next state WARMUP. s286..s288 are set to 1 on that same cycle; all other bits stay 0.
  - load_valid outside LOAD is ignored.
- Trivium step, repeated OUT_W times combinationally per clock (unrolled chain):
  - t1=s66^s93, t2=s162^s177, t3=s243^s288, z=t1^t2^t3.
  - t1^=s91&s92^s171, t2^=s175&s176^s264, t3^=s286&s287^s69.
  - Shift: s1..s93←(t3,s1..s92), s94..s177←(t1,s94..s176), s178..s288←(t2,s178..s287).
  - Step k (0-based) produces ks bit k.
- WARMUP: one OUT_W-step advance per cycle, z discarded. Lasts exactly WARMUP/OUT_W cycles, then RUN. busy=1 throughout.
- RUN: advance when (!ks_valid || ks_ready).
  - On advance: ks_data←z word, ks_valid←1.
  - If ks_valid && !ks_ready: s and ks_data hold (no keystream bit lost or duplicated).
  - First ks_valid asserts 1 cycle after entering RUN. Sustained ks_ready=1 yields one word per cycle.
- IDLE: no activity; ks_valid=0.
- ena=0 mid-handshake: ks_valid/ks_data hold; a transfer counts only on cycles with ena=1.

Optional Feature:
- Macro TRIVIUM_KS_COUNT_EN.
- Defined: ks_count increments on every cycle with ena && ks_valid && ks_ready, saturates at 0xFFFFFFFF, clears on load_start and reset.
- Undefined: ks_count tied to 32'd0 and no counter flops are synthesised. Port list is identical in both cases.

Test Plan:
- Reset mid-WARMUP: assert rst_n=0 → all outputs 0 immediately (async), state IDLE after release; ks_valid stays 0 without a new load.
- Load key=0x00..0 and IV=0x00..0 with OUT_W=8 and ks_ready=1 → busy high for 20 load cycles + 144 warm-up cycles; first 64 ks_data bytes match the bit-serial golden Trivium model (eSTREAM reference) for the same key/IV.
- Load key bytes 0x01..0x0A and IV bytes 0xF0..0xF9, sweeping OUT_W=1, 8, 32 → concatenated keystream (bit 0 first) is identical across all widths for the first 1024 bits.
- Random ks_ready (50%) in RUN → received words equal the ks_ready=1 stream with no gaps or repeats; ks_data is stable while ks_valid && !ks_ready.
- load_start asserted in RUN with the same key/IV → after reload and warm-up the keystream restarts from the first word; ks_count returns to 0 and then counts 1, 2, 3.
- ena=0 for 10 cycles during WARMUP and RUN → total warm-up stays exactly WARMUP/OUT_W enabled cycles and the keystream is unchanged vs. ena=1 throughout; with TRIVIUM_KS_COUNT_EN undefined, ks_count is 0 always.

Source files
------------

// File: rtl/trivium_keystream_par.sv
// Trivium keystream generator: byte-serial key/IV load, internal warm-up, OUT_W bits per cycle on a valid/ready port.
// Optional macro TRIVIUM_KS_COUNT_EN enables the saturating delivered-word counter on ks_count.
module trivium_keystream_par #(
  parameter int OUT_W  = 8,
  parameter int WARMUP = 1152
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             load_start,
  input  logic             load_valid,
  input  logic [7:0]       load_data,
  output logic             load_ready,
  output logic             busy,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic [OUT_W-1:0] ks_data,
  output logic [31:0]      ks_count
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WARM, S_RUN} state_t;

  localparam int WARM_CYCLES = WARMUP / OUT_W;
  localparam int RND_W       = (WARM_CYCLES > 1) ? $clog2(WARM_CYCLES) : 1;

  state_t           state;
  logic [288:1]     s;          // s[i] is Trivium state bit s_i
  logic [4:0]       byte_cnt;
  logic [RND_W-1:0] round_cnt;

  logic [288:1]     s_next;
  logic [OUT_W-1:0] z_word;
  logic [8:0]       load_pos;

  // OUT_W Trivium steps chained combinationally; step k yields keystream bit k.
  always_comb begin
    logic [288:1] v;
    logic         t1, t2, t3;
    // NOTE: every variable gets a default before any branch or loop so no latch is inferred.
    v      = s;
    t1     = 1'b0;
    t2     = 1'b0;
    t3     = 1'b0;
    z_word = '0;
    for (int k = 0; k < OUT_W; k++) begin
      t1        = v[66]  ^ v[93];
      t2        = v[162] ^ v[177];
      t3        = v[243] ^ v[288];
      z_word[k] = t1 ^ t2 ^ t3;
      t1        = t1 ^ (v[91]  & v[92])  ^ v[171];
      t2        = t2 ^ (v[175] & v[176]) ^ v[264];
      t3        = t3 ^ (v[286] & v[287]) ^ v[69];
      v         = {v[287:178], t2, v[176:94], t1, v[92:1], t3};
    end
    s_next = v;
  end

  // Key bytes fill s1..s80, IV bytes fill s94..s173, LSB first.
  always_comb begin
    load_pos = 9'd1;
    if (byte_cnt < 5'd10) load_pos = 9'(byte_cnt) * 9'd8 + 9'd1;
    else                  load_pos = (9'(byte_cnt) - 9'd10) * 9'd8 + 9'd94;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      s         <= '0;
      byte_cnt  <= '0;
      round_cnt <= '0;
      ks_valid  <= 1'b0;
      ks_data   <= '0;
    end else if (ena) begin
      if (load_start) begin
        state     <= S_LOAD;
        s         <= '0;
        byte_cnt  <= '0;
        round_cnt <= '0;
        ks_valid  <= 1'b0;
      end else begin
        case (state)
          S_LOAD: if (load_valid) begin
            s[load_pos +: 8] <= load_data;
            if (byte_cnt == 5'd19) begin
              s[288:286] <= 3'b111;
              byte_cnt   <= '0;
              state      <= S_WARM;
            end else begin
              byte_cnt <= byte_cnt + 5'd1;
            end
          end
          S_WARM: begin
            s <= s_next;
            if (round_cnt == RND_W'(WARM_CYCLES - 1)) begin
              round_cnt <= '0;
              state     <= S_RUN;
            end else begin
              round_cnt <= round_cnt + 1'b1;
            end
          end
          // A stalled word holds together with s, so no keystream bit is lost or repeated.
          S_RUN: if (!ks_valid || ks_ready) begin
            s        <= s_next;
            ks_data  <= z_word;
            ks_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign load_ready = (state == S_LOAD);
  assign busy       = (state == S_LOAD) || (state == S_WARM);

`ifdef TRIVIUM_KS_COUNT_EN
  logic [31:0] ks_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks_cnt_q <= '0;
    end else if (ena) begin
      if (load_start)                                    ks_cnt_q <= '0;
      else if (ks_valid && ks_ready && (ks_cnt_q != '1)) ks_cnt_q <= ks_cnt_q + 32'd1;
    end
  end

  assign ks_count = ks_cnt_q;
`else
  assign ks_count = 32'd0;
`endif

endmodule

// File: tb/tb_trivium_keystream_par.sv
// Scoreboard bench: three widths (1, 8, 32) share one load bus and are checked against a bit-serial Trivium model.
module tb_trivium_keystream_par;

  localparam int WARMUP = 1152;
  localparam int NBITS  = 1024;
`ifdef TRIVIUM_KS_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, ena, load_start, load_valid;
  logic [7:0] load_data;

  logic lr8, b8, v8, r8;   logic [7:0]  d8;  logic [31:0] c8;
  logic lr32, b32, v32, r32; logic [31:0] d32; logic [31:0] c32;
  logic lr1, b1, v1, r1;   logic [0:0]  d1;  logic [31:0] c1;

  always #5 clk = ~clk;

  trivium_keystream_par #(.OUT_W(8), .WARMUP(WARMUP)) u8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(lr8), .busy(b8), .ks_valid(v8), .ks_ready(r8),
    .ks_data(d8), .ks_count(c8));
  trivium_keystream_par #(.OUT_W(32), .WARMUP(WARMUP)) u32 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(lr32), .busy(b32), .ks_valid(v32), .ks_ready(r32),
    .ks_data(d32), .ks_count(c32));
  trivium_keystream_par #(.OUT_W(1), .WARMUP(WARMUP)) u1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(lr1), .busy(b1), .ks_valid(v1), .ks_ready(r1),
    .ks_data(d1), .ks_count(c1));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: straight bit-serial Trivium from the algorithm definition.
  logic [7:0] load_bytes[20];
  bit         ref_bits[NBITS];

  task automatic build_ref();
    bit st[289];
    bit t1, t2, t3, z;
    for (int i = 0; i < 289; i++) st[i] = 1'b0;
    for (int i = 0; i < 80; i++) begin
      st[i + 1]  = load_bytes[i / 8][i % 8];
      st[i + 94] = load_bytes[10 + i / 8][i % 8];
    end
    st[286] = 1'b1; st[287] = 1'b1; st[288] = 1'b1;
    for (int n = 0; n < WARMUP + NBITS; n++) begin
      t1 = st[66] ^ st[93];
      t2 = st[162] ^ st[177];
      t3 = st[243] ^ st[288];
      z  = t1 ^ t2 ^ t3;
      t1 = t1 ^ (st[91] & st[92]) ^ st[171];
      t2 = t2 ^ (st[175] & st[176]) ^ st[264];
      t3 = t3 ^ (st[286] & st[287]) ^ st[69];
      for (int i = 288; i > 1; i--) st[i] = st[i - 1];
      st[1] = t3; st[94] = t1; st[178] = t2;
      if (n >= WARMUP) ref_bits[n - WARMUP] = z;
    end
  endtask

  // Scoreboard queues and ready generation.
  logic [7:0]  q8[$];
  logic [31:0] q32[$];
  logic        q1[$];
  int rdy_mode = 0;  // 0: never, 1: always, 2: random 50%

  function automatic logic rdy_bit(input int sz);
    if (sz == 0)         return 1'b0;
    if (rdy_mode == 1)   return 1'b1;
    if (rdy_mode == 2)   return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  initial begin
    r8 = 1'b0; r32 = 1'b0; r1 = 1'b0;
    forever begin
      @(posedge clk); #2;
      r8 = rdy_bit(q8.size()); r32 = rdy_bit(q32.size()); r1 = rdy_bit(q1.size());
    end
  end

  // Monitors: pop expected word on each transfer; a stalled word must stay put.
  int xfer8 = 0;
  logic hold8 = 0, hold32 = 0, hold1 = 0;
  logic [7:0] hd8; logic [31:0] hd32; logic [0:0] hd1;

  always @(negedge clk) begin
    if (!rst_n) begin hold8 = 0; xfer8 = 0; end
    else begin
      if (hold8) begin check("ks8_hold_valid", 64'(v8), 64'd1); check("ks8_hold_data", 64'(d8), 64'(hd8)); end
      if (ena && load_start) begin hold8 = 0; xfer8 = 0; end
      else begin
        if (ena && v8 && r8) begin
          if (q8.size() == 0) check("ks8_unexpected_word", 64'(d8), 64'hDEAD);
          else check("ks8_data", 64'(d8), 64'(q8.pop_front()));
          check("ks8_count", 64'(c8), COUNT_EN ? 64'(xfer8) : 64'd0);
          xfer8++;
        end
        hold8 = v8 && !(ena && r8);
        hd8   = d8;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) hold32 = 0;
    else begin
      if (hold32) begin check("ks32_hold_valid", 64'(v32), 64'd1); check("ks32_hold_data", 64'(d32), 64'(hd32)); end
      if (ena && load_start) hold32 = 0;
      else begin
        if (ena && v32 && r32) begin
          if (q32.size() == 0) check("ks32_unexpected_word", 64'(d32), 64'hDEAD);
          else check("ks32_data", 64'(d32), 64'(q32.pop_front()));
        end
        hold32 = v32 && !(ena && r32);
        hd32   = d32;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) hold1 = 0;
    else begin
      if (hold1) begin check("ks1_hold_valid", 64'(v1), 64'd1); check("ks1_hold_data", 64'(d1), 64'(hd1)); end
      if (ena && load_start) hold1 = 0;
      else begin
        if (ena && v1 && r1) begin
          if (q1.size() == 0) check("ks1_unexpected_bit", 64'(d1), 64'hDEAD);
          else check("ks1_data", 64'(d1), 64'(q1.pop_front()));
        end
        hold1 = v1 && !(ena && r1);
        hd1   = d1;
      end
    end
  end

  // Enabled busy / load_ready cycle counters.
  int busy8 = 0, busy32 = 0, busy1 = 0, lrdy8 = 0;
  always @(negedge clk) if (rst_n && ena) begin
    if (b8)  busy8++;
    if (b32) busy32++;
    if (b1)  busy1++;
    if (lr8) lrdy8++;
  end

  task automatic do_load();
    int keep;
    @(posedge clk); #1;
    keep = rdy_mode; rdy_mode = 0;
    build_ref();
    @(posedge clk); #1;
    load_start = 1'b1;
    q8.delete(); q32.delete(); q1.delete();
    for (int w = 0; w < NBITS / 8; w++) begin
      logic [7:0] x;
      for (int k = 0; k < 8; k++) x[k] = ref_bits[w * 8 + k];
      q8.push_back(x);
    end
    for (int w = 0; w < NBITS / 32; w++) begin
      logic [31:0] x;
      for (int k = 0; k < 32; k++) x[k] = ref_bits[w * 32 + k];
      q32.push_back(x);
    end
    for (int w = 0; w < NBITS; w++) q1.push_back(ref_bits[w]);
    @(posedge clk); #1;
    load_start = 1'b0;
    rdy_mode   = keep;
    busy8 = 0; busy32 = 0; busy1 = 0; lrdy8 = 0;
    for (int b = 0; b < 20; b++) begin
      load_valid = 1'b1; load_data = load_bytes[b];
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
  endtask

  task automatic drain(input int budget, input bit jiggle);
    int n = 0;
    while ((q8.size() + q32.size() + q1.size()) != 0 && n < budget) begin
      if (jiggle) begin load_valid = 1'($urandom_range(0, 1)); load_data = 8'($urandom); end
      @(posedge clk); #1;
      n++;
    end
    load_valid = 1'b0;
    check("drain_remaining", 64'(q8.size() + q32.size() + q1.size()), 64'd0);
  endtask

  task automatic check_busy_counts();
    check("busy_cycles_w8", 64'(busy8), 64'd164);
    check("busy_cycles_w32", 64'(busy32), 64'd56);
    check("busy_cycles_w1", 64'(busy1), 64'd1172);
    check("load_ready_cycles_w8", 64'(lrdy8), 64'd20);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_w8"}, {c8, d8, 5'b0, lr8, b8, v8}, 64'd0);
    check({tag, "_w32"}, {c32, d32}, 64'd0);
    check({tag, "_w32_ctl"}, {61'd0, lr32, b32, v32}, 64'd0);
    check({tag, "_w1"}, {c1, 28'd0, d1, lr1, b1, v1}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = 8'd0;
    #3;
    check_all_zero("reset_state");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_all_zero("idle_after_reset");

    // All-zero key/IV, ready always, with first-word latency.
    for (int b = 0; b < 20; b++) load_bytes[b] = 8'h00;
    rdy_mode = 1;
    do_load();
    repeat (143) @(posedge clk);
    #1 check("last_warm_busy", 64'({b8, v8}), 64'b10);
    @(posedge clk); #1 check("run_entry", 64'({b8, v8}), 64'b00);
    @(posedge clk); #1 check("first_valid", 64'(v8), 64'd1);
    drain(4000, 1'b0);
    check_busy_counts();

    // Key 01..0A / IV F0..F9, random ready, load bus noise outside LOAD.
    for (int b = 0; b < 10; b++) begin load_bytes[b] = 8'(b + 1); load_bytes[10 + b] = 8'(8'hF0 + b); end
    rdy_mode = 2;
    do_load();
    drain(8000, 1'b1);
    check_busy_counts();

    // Reload mid-RUN with the same key/IV: stream restarts, counter restarts.
    rdy_mode = 1;
    do_load();
    begin
      int n = 0;
      while (q8.size() > 120 && n < 2000) begin @(posedge clk); #1; n++; end
    end
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    do_load();
    check("count_after_reload", 64'(c8), 64'd0);
    rdy_mode = 1;
    drain(4000, 1'b0);

    // Random key/IV with ena gaps in WARMUP and RUN.
    for (int b = 0; b < 20; b++) load_bytes[b] = 8'($urandom);
    rdy_mode = 2;
    do_load();
    repeat (40) @(posedge clk);
    #1 ena = 1'b0;
    repeat (10) @(posedge clk);
    #1 ena = 1'b1;
    begin
      int n = 0;
      while (q8.size() > 100 && n < 2000) begin @(posedge clk); #1; n++; end
    end
    ena = 1'b0;
    repeat (10) @(posedge clk);
    #1 ena = 1'b1;
    drain(8000, 1'b0);
    check_busy_counts();

    // One more random key/IV with random ready.
    for (int b = 0; b < 20; b++) load_bytes[b] = 8'($urandom);
    do_load();
    drain(8000, 1'b0);

    // Asynchronous reset in the middle of WARMUP.
    rdy_mode = 0;
    do_load();
    repeat (50) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    q8.delete(); q32.delete(); q1.delete();
    rdy_mode = 1;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      repeat (20) @(posedge clk);
      #1 check("idle_no_output", 64'({v8, b8, v32, b32, v1, b1}), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
